lcd_write_engine: RTL and testbench

//   Byte-level HD44780 bus driver, placed between the LCD_controller sequencer and the DE2 LCD pins.
//   - Runs the power-up delay and a fixed init sequence.
//   - Then accepts one command/data byte per valid/ready handshake.
//   - Generates RS/EN/DATA setup, pulse and hold timing, then waits out the LCD execution time.
//   - Upstream logic sees only a handshake and never counts LCD delays itself.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_write_engine_if.sv | 24 ++
 rtl/lcd_delay_counter.sv | 25 ++
 rtl/lcd_write_engine.sv | 191 +++++++++++++++++++
 tb/tb_lcd_write_engine.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write engine: FSM states, the
// power-on init ROM, command codes and small constant helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        SETUP,
        EN_HI,
        HOLD,
        EXEC,
        IDLE
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    // Entry 0 is the first byte sent after the power-up wait.
    localparam int INIT_COUNT = 4;
    localparam logic [INIT_COUNT-1:0][7:0] INIT_ROM = {8'h06, CMD_CLEAR, 8'h0C, 8'h38};

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A state lasting t cycles reloads the down-counter with t-1; zero means one cycle.
    function automatic int cyclesToLoad(input int t);
        return (t <= 0) ? 0 : t - 1;
    endfunction

    // Clear and home (and the unused 0x03) share all-zero upper bits and need the long wait.
    function automatic logic isLongExec(input logic rs, input logic [5:0] upperBits);
        return !rs && (upperBits == CMD_HOME[7:2]);
    endfunction

endpackage

// File: rtl/lcd_write_engine_if.sv
// Byte write handshake between the LCD sequencer (master) and the
// write engine (slave).
interface lcd_write_engine_if;

    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_rs,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_rs,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by every timed state of the write engine.
// It stops at zero instead of wrapping, so expired stays high until reloaded.
module lcd_delay_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // Reload on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 byte write engine: runs the power-up wait and init ROM, then
// accepts one byte per handshake and generates RS/EN/DATA timing plus the
// panel execution wait, so the upstream sequencer never counts delays.
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_EN_HIGH = 13,
    parameter int T_HOLD    = 2,
    parameter int T_SHORT   = 2000,
    parameter int T_LONG    = 82000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    lcd_write_engine_if.slave bus,
    output logic              init_done,
    output logic              busy,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic              LCD_EN,
    output logic [7:0]        LCD_DATA
);

    localparam int T_MAX = maxOf(maxOf(maxOf(T_POWERUP, T_SETUP), maxOf(T_EN_HIGH, T_HOLD)),
                                 maxOf(maxOf(T_SHORT, T_LONG), 1));
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(cyclesToLoad(T_POWERUP));
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(cyclesToLoad(T_SETUP));
    localparam logic [CNT_W-1:0] LD_EN_HIGH = CNT_W'(cyclesToLoad(T_EN_HIGH));
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(cyclesToLoad(T_HOLD));
    localparam logic [CNT_W-1:0] LD_SHORT   = CNT_W'(cyclesToLoad(T_SHORT));
    localparam logic [CNT_W-1:0] LD_LONG    = CNT_W'(cyclesToLoad(T_LONG));
    localparam logic [1:0]       LAST_INIT  = 2'(INIT_COUNT - 1);

    lcd_state_t       r_state;
    lcd_state_t       w_nextState;
    logic [1:0]       r_initIdx;
    logic [1:0]       w_nextIdx;
    logic [1:0]       w_idxPlusOne;
    logic             r_initDone;
    logic             w_setInitDone;
    logic             r_lcdRs;
    logic             w_nextRs;
    logic [7:0]       r_lcdData;
    logic [7:0]       w_nextData;
    logic             r_lcdEn;
    logic             r_ready;
    logic             r_busy;
    logic             w_readyNext;
    logic             w_isLong;
    logic             w_cntLoad;
    logic [CNT_W-1:0] w_cntLoadVal;
    logic             w_load;
    logic [CNT_W-1:0] w_loadVal;
    logic             w_expired;

    assign w_idxPlusOne = r_initIdx + 2'd1;
    assign w_isLong     = isLongExec(r_lcdRs, r_lcdData[7:2]);

    // Reset forces a reload with the power-up wait, whatever state was active.
    assign w_load    = reset | w_cntLoad;
    assign w_loadVal = reset ? LD_POWERUP : w_cntLoadVal;

    lcd_delay_counter #(
        .WIDTH(CNT_W)
    ) u_delay (
        .clk      (CLOCK_50),
        .load     (w_load),
        .load_val (w_loadVal),
        .expired  (w_expired)
    );

    // State register; reset abandons any in-flight byte and restarts power-up.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= PWR_WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, counter reload and the byte to present on the next SETUP entry.
    always_comb begin
        w_nextState   = r_state;
        w_cntLoad     = 1'b0;
        w_cntLoadVal  = LD_SETUP;
        w_nextRs      = r_lcdRs;
        w_nextData    = r_lcdData;
        w_nextIdx     = r_initIdx;
        w_setInitDone = 1'b0;
        unique case (r_state)
            PWR_WAIT: begin
                if (w_expired) begin
                    w_nextState  = SETUP;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = LD_SETUP;
                    w_nextRs     = 1'b0;
                    w_nextData   = INIT_ROM[0];
                    w_nextIdx    = 2'd0;
                end
            end
            SETUP: begin
                if (w_expired) begin
                    w_nextState  = EN_HI;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = LD_EN_HIGH;
                end
            end
            EN_HI: begin
                if (w_expired) begin
                    w_nextState  = HOLD;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = LD_HOLD;
                end
            end
            HOLD: begin
                if (w_expired) begin
                    w_nextState  = EXEC;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = w_isLong ? LD_LONG : LD_SHORT;
                end
            end
            EXEC: begin
                if (w_expired) begin
                    if (!r_initDone && (r_initIdx != LAST_INIT)) begin
                        w_nextState  = SETUP;
                        w_cntLoad    = 1'b1;
                        w_cntLoadVal = LD_SETUP;
                        w_nextRs     = 1'b0;
                        w_nextData   = INIT_ROM[w_idxPlusOne];
                        w_nextIdx    = w_idxPlusOne;
                    end else begin
                        w_nextState   = IDLE;
                        w_setInitDone = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (bus.wr_valid && r_ready) begin
                    w_nextState  = SETUP;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = LD_SETUP;
                    w_nextRs     = bus.wr_rs;
                    w_nextData   = bus.wr_data;
                end
            end
            default: begin
                w_nextState  = PWR_WAIT;
                w_cntLoad    = 1'b1;
                w_cntLoadVal = LD_POWERUP;
            end
        endcase
    end

    // Ready rises one cycle after IDLE is entered and drops on the accepting edge.
    assign w_readyNext = (r_state == IDLE) && (w_nextState == IDLE);

    // Registered panel pins, handshake and status flags.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_initIdx  <= 2'd0;
            r_initDone <= 1'b0;
            r_lcdRs    <= 1'b0;
            r_lcdData  <= 8'h00;
            r_lcdEn    <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_initIdx <= w_nextIdx;
            r_lcdRs   <= w_nextRs;
            r_lcdData <= w_nextData;
            r_lcdEn   <= (w_nextState == EN_HI);
            r_ready   <= w_readyNext;
            r_busy    <= !w_readyNext;
            if (w_setInitDone) begin
                r_initDone <= 1'b1;
            end
        end
    end

    assign bus.wr_ready = r_ready;
    assign init_done    = r_initDone;
    assign busy         = r_busy;
    assign LCD_RS       = r_lcdRs;
    assign LCD_RW       = 1'b0;
    assign LCD_EN       = r_lcdEn;
    assign LCD_DATA     = r_lcdData;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed testbench for lcd_write_engine with shortened timing:
// power-up 20, setup 2, EN high 3, hold 2, short exec 10, long exec 40.
module tb_lcd_write_engine;

    localparam int LIMIT = 200;

    localparam logic [7:0] INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    // Low cycles between init pulses: hold 2 + exec + setup 2.
    localparam int INIT_GAP [3] = '{14, 14, 44};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       initDone;
    logic       busy;
    logic       lcdRs;
    logic       lcdRw;
    logic       lcdEn;
    logic [7:0] lcdData;

    int testsRun    = 0;
    int testsFailed = 0;
    int enPulses    = 0;

    lcd_write_engine_if bus();

    lcd_write_engine #(
        .T_POWERUP (20),
        .T_SETUP   (2),
        .T_EN_HIGH (3),
        .T_HOLD    (2),
        .T_SHORT   (10),
        .T_LONG    (40)
    ) dut (
        .CLOCK_50  (clock),
        .reset     (reset),
        .bus       (bus),
        .init_done (initDone),
        .busy      (busy),
        .LCD_RS    (lcdRs),
        .LCD_RW    (lcdRw),
        .LCD_EN    (lcdEn),
        .LCD_DATA  (lcdData)
    );

    // 100 MHz-style free-running clock for the bench.
    always #5 clock = ~clock;

    // Count every EN strobe the panel would see.
    always @(posedge lcdEn) enPulses++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rs, input logic [7:0] data);
        bus.wr_valid = valid;
        bus.wr_rs    = rs;
        bus.wr_data  = data;
    endtask

    task automatic waitEnHigh(output int n);
        n = 0;
        while (lcdEn !== 1'b1 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Called on the first negedge with EN high; measures the pulse and checks the bus.
    task automatic measurePulse(input logic expRs, input logic [7:0] expData, input string tag,
                                output int width);
        bit stable;
        stable = 1'b1;
        width  = 0;
        checkOutput({tag, "_rs"}, 32'(lcdRs), 32'(expRs));
        checkOutput({tag, "_data"}, 32'(lcdData), 32'(expData));
        while (lcdEn === 1'b1 && width < LIMIT) begin
            if (lcdRs !== expRs || lcdData !== expData) stable = 1'b0;
            @(negedge clock);
            width++;
        end
        checkOutput({tag, "_width"}, width, 3);
        checkOutput({tag, "_stable"}, 32'(stable), 1);
    endtask

    // Starts on the negedge after reset release; pre = cycles already spent since then.
    task automatic checkInit(input int pre, input string tag);
        int n;
        int w;
        int p0;
        p0 = enPulses;
        waitEnHigh(n);
        checkOutput({tag, "_pwrup_rise"}, pre + n, 22);
        for (int i = 0; i < 4; i++) begin
            measurePulse(1'b0, INIT_SEQ[i], $sformatf("%s_init%0d", tag, i), w);
            if (i == 0) checkOutput({tag, "_done_early"}, 32'(initDone), 0);
            if (i < 3) begin
                waitEnHigh(n);
                checkOutput($sformatf("%s_gap%0d", tag, i), n, INIT_GAP[i]);
            end
        end
        waitReady(n);
        checkOutput({tag, "_ready_after_init"}, n, 13);
        checkOutput({tag, "_init_done"}, 32'(initDone), 1);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 0);
        checkOutput({tag, "_init_pulses"}, enPulses - p0, 4);
    endtask

    // One handshake write; expTotal counts cycles from acceptance to ready high again.
    task automatic doWrite(input logic rs, input logic [7:0] data, input int expTotal,
                           input bit poke, input string tag);
        int n;
        int w;
        int total;
        int p0;
        p0 = enPulses;
        checkOutput({tag, "_ready_in"}, 32'(bus.wr_ready), 1);
        applyStimulus(1'b1, rs, data);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput({tag, "_ready_drop"}, 32'(bus.wr_ready), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 1);
        waitEnHigh(n);
        checkOutput({tag, "_setup"}, n, 2);
        total = n;
        measurePulse(rs, data, tag, w);
        total += w;
        if (poke) begin
            repeat (3) @(negedge clock);
            applyStimulus(1'b1, 1'b1, 8'h55);
            @(negedge clock);
            applyStimulus(1'b0, 1'b0, 8'h00);
            total += 4;
        end
        waitReady(n);
        total += n;
        checkOutput({tag, "_cycles"}, total, expTotal);
        checkOutput({tag, "_pulses"}, enPulses - p0, 1);
        checkOutput({tag, "_data_hold"}, 32'(lcdData), 32'(data));
    endtask

    // Linear directed sequence covering init, writes, back-to-back and reset.
    initial begin
        int n;
        int w;
        int total;
        int p0;

        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clock);
        checkOutput("rst_en", 32'(lcdEn), 0);
        checkOutput("rst_rs", 32'(lcdRs), 0);
        checkOutput("rst_rw", 32'(lcdRw), 0);
        checkOutput("rst_data", 32'(lcdData), 0);
        checkOutput("rst_ready", 32'(bus.wr_ready), 0);
        checkOutput("rst_init_done", 32'(initDone), 0);
        checkOutput("rst_busy", 32'(busy), 1);
        reset = 1'b0;

        // valid during the power-up wait must be ignored
        applyStimulus(1'b1, 1'b1, 8'hAA);
        repeat (5) @(negedge clock);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkInit(5, "init");

        doWrite(1'b1, 8'h41, 18, 1'b0, "char41");
        doWrite(1'b0, 8'h01, 48, 1'b1, "clear");
        doWrite(1'b0, 8'h80, 18, 1'b0, "ddram80");
        doWrite(1'b0, 8'h03, 48, 1'b0, "cmd03");
        doWrite(1'b0, 8'h04, 18, 1'b0, "cmd04");
        doWrite(1'b1, 8'h01, 18, 1'b0, "char01");

        // back-to-back with valid held high
        p0 = enPulses;
        applyStimulus(1'b1, 1'b1, 8'h48);
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 8'h49);
        checkOutput("b2b_ready_drop", 32'(bus.wr_ready), 0);
        waitEnHigh(n);
        total = n;
        measurePulse(1'b1, 8'h48, "b2b48", w);
        total += w;
        waitReady(n);
        total += n;
        checkOutput("b2b48_cycles", total, 18);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("b2b49_latched", 32'(lcdData), 32'(8'h49));
        checkOutput("b2b49_ready_drop", 32'(bus.wr_ready), 0);
        waitEnHigh(n);
        checkOutput("b2b49_setup", n, 2);
        measurePulse(1'b1, 8'h49, "b2b49", w);
        waitReady(n);
        checkOutput("b2b49_ready_wait", n, 13);
        checkOutput("b2b_pulses", enPulses - p0, 2);

        // reset in the middle of an EN pulse
        applyStimulus(1'b1, 1'b1, 8'h42);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitEnHigh(n);
        checkOutput("mid_en_high", 32'(lcdEn), 1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("mid_rst_en", 32'(lcdEn), 0);
        checkOutput("mid_rst_init_done", 32'(initDone), 0);
        checkOutput("mid_rst_ready", 32'(bus.wr_ready), 0);
        checkOutput("mid_rst_busy", 32'(busy), 1);
        checkOutput("mid_rst_data", 32'(lcdData), 0);
        reset = 1'b0;
        checkInit(0, "reinit");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
